// File: rtl/aap_instr_encoder.sv
// rtl/aap_instr_encoder.sv - packs decoded AAP instruction fields into a handshaked halfword stream
module aap_instr_encoder #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    COUNT_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_long,
    input  logic [5:0]             in_opcode,
    input  logic [5:0]             in_dest,
    input  logic [5:0]             in_src1,
    input  logic [5:0]             in_src2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_word,
    output logic                   out_last,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   field_err
);

    // IDLE: nothing on the output; SHORT/HI: final halfword shown; LO: first half of a long form
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHORT = 2'd1,
        S_LO    = 2'd2,
        S_HI    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        hi_pending;
    logic        hi_pending_nxt;
    logic [15:0] hi_word;
    logic [15:0] hi_word_nxt;
    logic [15:0] out_word_nxt;
    logic        field_err_nxt;

    logic        accept;
    logic        handshake;
    logic [15:0] short_enc;
    logic [15:0] lo_enc;
    logic [15:0] hi_enc;
    logic        upper_bits_set;

    // Both flags come straight from registered state, so in_* never reaches out_* combinationally
    assign out_valid = (state != S_IDLE);
    assign out_last  = (state == S_SHORT) || (state == S_HI);

    // A new bundle may enter only when no high halfword is queued and the output slot frees up
    assign in_ready  = !hi_pending && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    assign short_enc      = {1'b0, in_opcode, in_dest[2:0], in_src1[2:0], in_src2[2:0]};
    assign lo_enc         = {1'b1, in_opcode, in_dest[2:0], in_src1[2:0], in_src2[2:0]};
    assign hi_enc         = {1'b1, 6'b000000, in_dest[5:3], in_src1[5:3], in_src2[5:3]};
    assign upper_bits_set = |{in_dest[5:3], in_src1[5:3], in_src2[5:3]};

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: shorts and high halves chain back-to-back; a low half always moves on to its high half
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = in_long ? S_LO : S_SHORT;
                end
            end
            S_SHORT, S_HI: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = in_long ? S_LO : S_SHORT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_LO: begin
                if (out_ready) begin
                    state_nxt = S_HI;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values: load a fresh encoding on accept, swap in the high half after LO
    always_comb begin
        out_word_nxt   = out_word;
        hi_word_nxt    = hi_word;
        hi_pending_nxt = hi_pending;
        field_err_nxt  = 1'b0;
        if (accept) begin
            if (in_long) begin
                out_word_nxt   = lo_enc;
                hi_word_nxt    = hi_enc;
                hi_pending_nxt = 1'b1;
            end else begin
                out_word_nxt   = short_enc;
                field_err_nxt  = upper_bits_set;
            end
        end else if ((state == S_LO) && out_ready) begin
            out_word_nxt   = hi_word;
            hi_pending_nxt = 1'b0;
        end
    end

    // Datapath registers and the running address / instruction counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_word    <= '0;
            hi_word     <= '0;
            hi_pending  <= 1'b0;
            field_err   <= 1'b0;
            out_addr    <= START_ADDR;
            instr_count <= '0;
        end else begin
            out_word   <= out_word_nxt;
            hi_word    <= hi_word_nxt;
            hi_pending <= hi_pending_nxt;
            field_err  <= field_err_nxt;
            if (handshake) begin
                out_addr <= out_addr + ADDR_WIDTH'(1);
                if (out_last) begin
                    instr_count <= instr_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aap_instr_encoder.sv
// tb/tb_aap_instr_encoder.sv - self-checking bench for aap_instr_encoder
module tb_aap_instr_encoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_long;
    logic [5:0]  in_opcode;
    logic [5:0]  in_dest;
    logic [5:0]  in_src1;
    logic [5:0]  in_src2;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_word;
    logic        out_last;
    logic [15:0] out_addr;
    logic [15:0] instr_count;
    logic        field_err;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [15:0] w_out_word;
    logic        w_out_last;
    logic [15:0] w_out_addr;
    logic [15:0] w_instr_count;
    logic        w_field_err;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    aap_instr_encoder #(.ADDR_WIDTH(16), .COUNT_WIDTH(16), .START_ADDR(16'h0000)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_long(in_long),
        .in_opcode(in_opcode), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last), .out_addr(out_addr), .instr_count(instr_count),
        .field_err(field_err)
    );

    aap_instr_encoder #(.ADDR_WIDTH(16), .COUNT_WIDTH(16), .START_ADDR(16'hFFFF)) dut_wrap (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_long(in_long),
        .in_opcode(in_opcode), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_word(w_out_word),
        .out_last(w_out_last), .out_addr(w_out_addr), .instr_count(w_instr_count),
        .field_err(w_field_err)
    );

    task automatic set_in(input logic v, input logic lng, input int op, input int d,
                          input int s1, input int s2);
        in_valid  = v;
        in_long   = lng;
        in_opcode = 6'(op);
        in_dest   = 6'(d);
        in_src1   = 6'(s1);
        in_src2   = 6'(s2);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_word !== 16'h0000) $display("FAIL reset_out_word got %h want 0000", out_word); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else passed++;
        checks++; if (field_err !== 1'b0) $display("FAIL reset_field_err got %b want 0", field_err); else passed++;
        checks++; if (out_addr !== 16'h0000) $display("FAIL reset_out_addr got %h want 0000", out_addr); else passed++;
        checks++; if (instr_count !== 16'h0000) $display("FAIL reset_instr_count got %h want 0000", instr_count); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (w_out_addr !== 16'hFFFF) $display("FAIL reset_wrap_addr got %h want ffff", w_out_addr); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_short();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 1, 0, 1, 2);
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) $display("FAIL short_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_word !== 16'h020A) $display("FAIL short_word got %h want 020a", out_word); else passed++;
        checks++; if (out_last !== 1'b1) $display("FAIL short_last got %b want 1", out_last); else passed++;
        checks++; if (out_addr !== 16'h0000) $display("FAIL short_addr got %h want 0000", out_addr); else passed++;
        checks++; if (field_err !== 1'b0) $display("FAIL short_field_err got %b want 0", field_err); else passed++;
        @(negedge clock);
        checks++; if (instr_count !== 16'd1) $display("FAIL short_count got %0d want 1", instr_count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL short_idle got %b want 0", out_valid); else passed++;
        checks++; if (out_addr !== 16'h0001) $display("FAIL short_addr_next got %h want 0001", out_addr); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 1, 0, 1, 2);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", in_ready); else passed++;
        @(negedge clock);
        checks++; if (out_word !== 16'h020A) $display("FAIL b2b_word0 got %h want 020a", out_word); else passed++;
        checks++; if (out_addr !== 16'h0000) $display("FAIL b2b_addr0 got %h want 0000", out_addr); else passed++;
        set_in(1'b1, 1'b0, 1, 1, 0, 2);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", in_ready); else passed++;
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        checks++; if (out_word !== 16'h0242) $display("FAIL b2b_word1 got %h want 0242", out_word); else passed++;
        checks++; if (out_addr !== 16'h0001) $display("FAIL b2b_addr1 got %h want 0001", out_addr); else passed++;
        checks++; if (instr_count !== 16'd1) $display("FAIL b2b_count1 got %0d want 1", instr_count); else passed++;
        @(negedge clock);
        checks++; if (instr_count !== 16'd2) $display("FAIL b2b_count2 got %0d want 2", instr_count); else passed++;
    endtask

    task automatic test_long();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 1'b1, 6'h05, 6'h09, 6'h12, 6'h3F);
        @(negedge clock);
        set_in(1'b1, 1'b0, 1, 0, 1, 2);
        #1;
        checks++; if (out_word !== 16'h8A57) $display("FAIL long_lo_word got %h want 8a57", out_word); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL long_lo_last got %b want 0", out_last); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL long_lo_in_ready got %b want 0", in_ready); else passed++;
        checks++; if (field_err !== 1'b0) $display("FAIL long_field_err got %b want 0", field_err); else passed++;
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        checks++; if (out_word !== 16'h8057) $display("FAIL long_hi_word got %h want 8057", out_word); else passed++;
        checks++; if (out_last !== 1'b1) $display("FAIL long_hi_last got %b want 1", out_last); else passed++;
        checks++; if (out_addr !== 16'h0001) $display("FAIL long_hi_addr got %h want 0001", out_addr); else passed++;
        checks++; if (instr_count !== 16'd0) $display("FAIL long_count_mid got %0d want 0", instr_count); else passed++;
        @(negedge clock);
        checks++; if (instr_count !== 16'd1) $display("FAIL long_count_end got %0d want 1", instr_count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL long_idle got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 1'b1, 6'h05, 6'h09, 6'h12, 6'h3F);
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_word !== 16'h8A57 || out_valid !== 1'b1)
                $display("FAIL stall_word[%0d] got %h/%b want 8a57/1", i, out_word, out_valid); else passed++;
            checks++; if (out_addr !== 16'h0000) $display("FAIL stall_addr[%0d] got %h want 0000", i, out_addr); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); else passed++;
            if (i == 3) out_ready = 1'b1;
            @(negedge clock);
        end
        checks++; if (out_word !== 16'h8057) $display("FAIL stall_release_word got %h want 8057", out_word); else passed++;
        checks++; if (out_addr !== 16'h0001) $display("FAIL stall_release_addr got %h want 0001", out_addr); else passed++;
    endtask

    task automatic test_field_err();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 1, 6'h09, 1, 2);
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        checks++; if (field_err !== 1'b1) $display("FAIL ferr_pulse got %b want 1", field_err); else passed++;
        checks++; if (out_word !== 16'h024A) $display("FAIL ferr_word got %h want 024a", out_word); else passed++;
        @(negedge clock);
        checks++; if (field_err !== 1'b0) $display("FAIL ferr_clear got %b want 0", field_err); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 1'b1, 6'h05, 6'h09, 6'h12, 6'h3F);
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clock);
        checks++; if (out_last !== 1'b1) $display("FAIL rmid_in_hi got %b want 1", out_last); else passed++;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_addr !== 16'h0000) $display("FAIL rmid_addr got %h want 0000", out_addr); else passed++;
        checks++; if (instr_count !== 16'd0) $display("FAIL rmid_count got %0d want 0", instr_count); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        set_in(1'b1, 1'b0, 1, 0, 1, 2);
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        checks++; if (out_word !== 16'h020A) $display("FAIL rmid_word got %h want 020a", out_word); else passed++;
        checks++; if (out_addr !== 16'h0000) $display("FAIL rmid_addr_after got %h want 0000", out_addr); else passed++;
        checks++; if (instr_count !== 16'd0) $display("FAIL rmid_count_before got %0d want 0", instr_count); else passed++;
        @(negedge clock);
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 1, 0, 1, 2);
        @(negedge clock);
        checks++; if (w_out_addr !== 16'hFFFF) $display("FAIL wrap_addr0 got %h want ffff", w_out_addr); else passed++;
        set_in(1'b1, 1'b0, 1, 1, 0, 2);
        @(negedge clock);
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        checks++; if (w_out_addr !== 16'h0000) $display("FAIL wrap_addr1 got %h want 0000", w_out_addr); else passed++;
        checks++; if (w_out_word !== 16'h0242) $display("FAIL wrap_word1 got %h want 0242", w_out_word); else passed++;
        @(negedge clock);
        checks++; if (w_out_addr !== 16'h0001) $display("FAIL wrap_addr2 got %h want 0001", w_out_addr); else passed++;
    endtask

    task automatic test_random();
        logic [16:0] q[$];
        logic [15:0] addr_m;
        logic [15:0] cnt_m;
        logic        ferr_m;
        logic        exp_ready;
        int          op, d, s1, s2;
        int          fails_before;
        do_reset();
        addr_m = 16'h0000;
        cnt_m  = 16'h0000;
        ferr_m = 1'b0;
        fails_before = checks - passed;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (out_valid !== (q.size() != 0))
                $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, out_valid, q.size() != 0); else passed++;
            if (q.size() != 0) begin
                checks++; if (out_word !== q[0][15:0] || out_last !== q[0][16])
                    $display("FAIL rnd_word cyc %0d got %h/%b want %h/%b", cyc, out_word, out_last, q[0][15:0], q[0][16]); else passed++;
                checks++; if (out_addr !== addr_m)
                    $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, out_addr, addr_m); else passed++;
            end
            checks++; if (instr_count !== cnt_m)
                $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, instr_count, cnt_m); else passed++;
            checks++; if (field_err !== ferr_m)
                $display("FAIL rnd_field_err cyc %0d got %b want %b", cyc, field_err, ferr_m); else passed++;

            op = $urandom_range(0, 63); d = $urandom_range(0, 63);
            s1 = $urandom_range(0, 63); s2 = $urandom_range(0, 63);
            if ($urandom_range(0, 2) == 0) begin
                d = d % 8; s1 = s1 % 8; s2 = s2 % 8;
            end
            set_in(($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1, op, d, s1, s2);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            checks++; if (in_ready !== exp_ready)
                $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_ready); else passed++;

            ferr_m = 1'b0;
            if (q.size() != 0 && out_ready) begin
                if (q[0][16]) cnt_m = cnt_m + 16'd1;
                addr_m = addr_m + 16'd1;
                void'(q.pop_front());
            end
            if (in_valid && exp_ready) begin
                if (in_long) begin
                    q.push_back({1'b0, 16'(32768 + op * 512 + (d % 8) * 64 + (s1 % 8) * 8 + (s2 % 8))});
                    q.push_back({1'b1, 16'(32768 + (d / 8) * 64 + (s1 / 8) * 8 + (s2 / 8))});
                end else begin
                    q.push_back({1'b1, 16'(op * 512 + (d % 8) * 64 + (s1 % 8) * 8 + (s2 % 8))});
                    ferr_m = (d >= 8) || (s1 >= 8) || (s2 >= 8);
                end
            end
            @(negedge clock);
            if ((checks - passed) - fails_before > 20) begin
                $display("FAIL rnd_abort too many errors at cyc %0d", cyc);
                break;
            end
        end
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n   = 1'b1;
        out_ready = 1'b1;
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        test_reset();
        test_short();
        test_back_to_back();
        test_long();
        test_stall();
        test_field_err();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
